// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter for two word sources feeding a small FIFO that drains onto the
// serial order link, MSB first, with a fixed idle gap after every frame.
module link_tx_arbiter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 4
) (
   input  logic                     clk,
   input  logic                     CPU_RESETN,
   input  logic                     req0_valid,
   input  logic [WIDTH-1:0]         req0_data,
   output logic                     req0_ready,
   input  logic                     req1_valid,
   input  logic [WIDTH-1:0]         req1_data,
   output logic                     req1_ready,
   output logic                     link_en_out,
   output logic                     link_data_out,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     busy
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned BW = $clog2(WIDTH);
   localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   state_t           state;
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] push_data;
   logic [BW-1:0]    bit_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             last_grant;
   logic             space;
   logic             push;
   logic             pop;

   // A slot freed by this cycle's pop only becomes visible next cycle.
   always_comb begin
      space      = fifo_count < CW'(DEPTH);
      req0_ready = space && req0_valid && (!req1_valid || last_grant);
      req1_ready = space && req1_valid && (!req0_valid || !last_grant);
      push       = req0_ready || req1_ready;
      push_data  = req0_ready ? req0_data : req1_data;
      pop        = (state == S_IDLE) && (fifo_count != '0);
      head       = mem[rd_ptr];
   end

   assign busy = (state != S_IDLE) || (fifo_count != '0);

   // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         last_grant <= 1'b1;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + PW'(1);
            last_grant <= req1_ready;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
   end

   // Frame FSM: shift_reg holds the bits still to be sent, already aligned so its MSB is next.
   always_ff @(posedge clk or negedge CPU_RESETN) begin
      if (!CPU_RESETN) begin
         state         <= S_IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         gap_cnt       <= '0;
         link_en_out   <= 1'b0;
         link_data_out <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               link_en_out   <= 1'b0;
               link_data_out <= 1'b0;
               if (pop) begin
                  shift_reg     <= {head[WIDTH-2:0], 1'b0};
                  bit_cnt       <= '0;
                  link_en_out   <= 1'b1;
                  link_data_out <= head[WIDTH-1];
                  state         <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (bit_cnt == BW'(WIDTH - 1)) begin
                  link_en_out   <= 1'b0;
                  link_data_out <= 1'b0;
                  gap_cnt       <= '0;
                  state         <= S_GAP;
               end else begin
                  link_data_out <= shift_reg[WIDTH-1];
                  shift_reg     <= {shift_reg[WIDTH-2:0], 1'b0};
                  bit_cnt       <= bit_cnt + BW'(1);
               end
            end
            S_GAP: begin
               link_en_out   <= 1'b0;
               link_data_out <= 1'b0;
               if (gap_cnt == GW'(GAP - 1)) begin
                  state <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: begin
               state         <= S_IDLE;
               link_en_out   <= 1'b0;
               link_data_out <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: directed and random traffic checked each cycle against a
// timeline model (word queue plus frame start times).
module tb_link_tx_arbiter;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned GAP   = 4;

   logic             clk = 1'b0;
   logic             CPU_RESETN;
   logic             req0_valid, req1_valid;
   logic [WIDTH-1:0] req0_data, req1_data;
   logic             req0_ready, req1_ready;
   logic             link_en_out, link_data_out;
   logic [2:0]       fifo_count;
   logic             busy;

   always #5 clk = ~clk;

   link_tx_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .GAP(GAP)) dut (
      .clk(clk), .CPU_RESETN(CPU_RESETN),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .link_en_out(link_en_out), .link_data_out(link_data_out),
      .fifo_count(fifo_count), .busy(busy)
   );

   int checks = 0;
   int passed = 0;

   // Model: queued words, who won last, and the edge at which the current frame started.
   logic [WIDTH-1:0] q[$];
   bit               lg;
   int               edge_n;
   int               pop_edge;
   int               next_pop;
   bit               have_frame;
   logic [WIDTH-1:0] cur;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      q.delete();
      lg         = 1'b1;
      have_frame = 1'b0;
      next_pop   = 0;
   endtask

   task automatic check_outputs();
      int  off;
      bit  en;
      bit  bsy;
      off = edge_n - pop_edge;
      en  = have_frame && (off < int'(WIDTH));
      bsy = (q.size() != 0) || (have_frame && off < int'(WIDTH + GAP));
      chk("link_en", link_en_out, en);
      chk("link_data", link_data_out, en ? cur[WIDTH-1-off] : 1'b0);
      chk("fifo_count", fifo_count, q.size());
      chk("busy", busy, bsy);
   endtask

   // One clock: drive at negedge, check readys, model the edge, check registered outputs.
   task automatic step(input bit v0, input logic [WIDTH-1:0] d0,
                       input bit v1, input logic [WIDTH-1:0] d1,
                       output bit a0, output bit a1);
      bit space;
      @(negedge clk);
      req0_valid = v0; req0_data = d0;
      req1_valid = v1; req1_data = d1;
      space = q.size() < DEPTH;
      a0 = space && v0 && (!v1 || lg);
      a1 = space && v1 && !a0;
      #1;
      chk("req0_ready", req0_ready, a0);
      chk("req1_ready", req1_ready, a1);
      @(posedge clk);
      edge_n++;
      if (q.size() > 0 && edge_n >= next_pop) begin
         cur        = q.pop_front();
         pop_edge   = edge_n;
         have_frame = 1'b1;
         next_pop   = edge_n + WIDTH + GAP + 1;
      end
      if (a0) begin q.push_back(d0); lg = 1'b0; end
      else if (a1) begin q.push_back(d1); lg = 1'b1; end
      #1;
      check_outputs();
   endtask

   task automatic idle(input int n);
      bit a0, a1;
      for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, a0, a1);
   endtask

   initial begin
      bit a0, a1, got;
      int n;
      int en_lo;
      int gap_max;
      edge_n = 0;
      pop_edge = 0;
      cur = '0;
      model_reset();
      req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0;
      CPU_RESETN = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_en", link_en_out, 1'b0);
      chk("rst_data", link_data_out, 1'b0);
      chk("rst_count", fifo_count, 3'd0);
      chk("rst_busy", busy, 1'b0);
      @(negedge clk);
      CPU_RESETN = 1;

      // Single word into empty FIFO, then idle until fully drained.
      step(1'b1, 32'hA5A5_0001, 1'b0, '0, a0, a1);
      chk("t1_accept", req0_ready, 1'b1);
      idle(WIDTH + GAP + 6);
      chk("t1_busy_done", busy, 1'b0);

      // Continuous contention, alternating grants starting with req0.
      for (int i = 0; i < 120; i++) step(1'b1, 32'h1111_1111, 1'b1, 32'h2222_2222, a0, a1);
      idle(5 * (WIDTH + GAP + 1));

      // Seven distinct words from req0, each held until accepted.
      for (int i = 0; i < 7; i++) begin
         n = 0;
         got = 0;
         while (!got && n < 400) begin
            step(1'b1, 32'h3000_0000 + i, 1'b0, '0, a0, a1);
            got = a0;
            n++;
         end
         chk("t3_accept", got, 1'b1);
      end
      idle(5 * (WIDTH + GAP + 1));

      // Two queued words: measure low time between frames.
      step(1'b1, 32'h5555_AAAA, 1'b0, '0, a0, a1);
      step(1'b1, 32'hF0F0_0F0F, 1'b0, '0, a0, a1);
      en_lo = 0;
      gap_max = 0;
      for (int i = 0; i < 2 * WIDTH + GAP + 4; i++) begin
         idle(1);
         if (!link_en_out) en_lo++;
         else begin
            if (en_lo > gap_max) gap_max = en_lo;
            en_lo = 0;
         end
      end
      chk("t6_gap_len", gap_max, GAP + 1);
      idle(WIDTH + GAP + 4);

      // Reset during bit 10 of a frame.
      step(1'b1, 32'hDEAD_BEEF, 1'b0, '0, a0, a1);
      idle(11);
      @(negedge clk);
      req0_valid = 0; req1_valid = 0;
      #2;
      CPU_RESETN = 0;
      #1;
      chk("t5_en", link_en_out, 1'b0);
      chk("t5_data", link_data_out, 1'b0);
      chk("t5_count", fifo_count, 3'd0);
      chk("t5_busy", busy, 1'b0);
      model_reset();
      @(negedge clk);
      CPU_RESETN = 1;
      step(1'b1, 32'h0BAD_F00D, 1'b1, 32'h1234_5678, a0, a1);
      chk("t5_first_req0", a0, 1'b1);
      idle(2 * (WIDTH + GAP + 1) + 2);

      // Random traffic with bursty and sparse phases.
      for (int ph = 0; ph < 8; ph++) begin
         int p0, p1;
         p0 = (ph % 2 == 0) ? 90 : 5;
         p1 = (ph % 3 == 0) ? 80 : 10;
         for (int i = 0; i < 300; i++) begin
            step($urandom_range(99) < p0, $urandom, $urandom_range(99) < p1, $urandom, a0, a1);
         end
      end
      idle(5 * (WIDTH + GAP + 1));
      chk("end_idle", busy, 1'b0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
